// File: rtl/mips_regfile_wb.sv
// rtl/mips_regfile_wb.sv - MIPS 32-entry register file with registered write-back and bypass
//
// Purpose:
//   General-purpose register file for a MIPS pipeline. It has one registered
//   write port, fed by the destination mux (rt / rd / $31), and two
//   combinational read ports (rs, rt).
//   - $0 is hardwired to zero.
//   - A committing write is forwarded to the read ports in the same cycle.
//   - stall suppresses the write, the write counter and the bypass.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   RegWrite  in   write enable from control
//   stall     in   pipeline hold; blocks the write this cycle
//   wa        in   write address [ADDR_W]
//   wd        in   write-back data [DATA_W]
//   ra1, ra2  in   read addresses [ADDR_W]
//   rd1, rd2  out  read data [DATA_W]
//   wr_count  out  committed-write count, saturating at 16'hFFFF
//
// Optional build macro REGFILE_DEBUG_PORT_EN:
//   dbg_addr  in   debug read address [ADDR_W]
//   dbg_data  out  non-bypassed read of reg[dbg_addr] [DATA_W]

module mips_regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RA_INDEX = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              stall,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
`ifdef REGFILE_DEBUG_PORT_EN
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    // The link register must be a real, writable entry (not $0).
    if (RA_INDEX < 1 || RA_INDEX >= DEPTH) begin : g_ra_index_check
        $error("RA_INDEX outside the writable register range");
    end

    logic [DATA_W-1:0] regs [DEPTH];
    logic              commit;

    // A write to $0 is dropped, so it must neither commit nor bypass.
    assign commit = RegWrite && !stall && (wa != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (commit) begin
            regs[wa] <= wd;
            if (wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // Read priority: reset forces 0, then the same-cycle write, then storage.
    // commit already excludes wa==0, so address 0 can never pick up bypass data.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!reset) begin
            if (commit && (ra1 == wa)) begin
                rd1 = wd;
            end else if (ra1 != '0) begin
                rd1 = regs[ra1];
            end
            if (commit && (ra2 == wa)) begin
                rd2 = wd;
            end else if (ra2 != '0) begin
                rd2 = regs[ra2];
            end
        end
    end

`ifdef REGFILE_DEBUG_PORT_EN
    // Display path shows committed contents only; it has no bypass.
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`endif

endmodule

// File: tb/tb_mips_regfile_wb.sv
// tb/tb_mips_regfile_wb.sv - randomized self-checking bench for mips_regfile_wb against an array model

module tb_mips_regfile_wb;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int RA_INDEX = 31;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWrite;
    logic              stall;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [15:0]       wr_count;
`ifdef REGFILE_DEBUG_PORT_EN
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: what the register file should hold, and how many
    // writes have committed.
    logic [DATA_W-1:0] model_regs [32];
    int                model_count;

    mips_regfile_wb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .RA_INDEX(RA_INDEX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .RegWrite(RegWrite),
        .stall   (stall),
        .wa      (wa),
        .wd      (wd),
        .ra1     (ra1),
        .ra2     (ra2),
`ifdef REGFILE_DEBUG_PORT_EN
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
`endif
        .rd1     (rd1),
        .rd2     (rd2),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    function automatic bit writes_now();
        return !reset && RegWrite && !stall && (wa != 0);
    endfunction

    // Expected read value from the architectural rules:
    // - zero under reset or for $0;
    // - the write data on a same-cycle committing write;
    // - otherwise the stored value.
    function automatic logic [DATA_W-1:0] expect_rd(input logic [ADDR_W-1:0] a);
        if (reset || a == 0) return '0;
        if (writes_now() && a == wa) return wd;
        return model_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_count = 0;
    endtask

    // Advance one clock edge, applying the write rule to the model, then
    // settle 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        if (writes_now()) begin
            model_regs[wa] = wd;
            if (model_count < 65535) model_count = model_count + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b1; stall = 1'b0; wa = 5'd3; wd = 32'hFFFF_0000;
        ra1 = '0; ra2 = '0;
`ifdef REGFILE_DEBUG_PORT_EN
        dbg_addr = '0;
`endif
        model_clear();
        #2;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            checks++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d rd1=%h rd2=%h exp 0", i, rd1, rd2);
            end
        end
        // Edges while reset is held must not write, even with RegWrite=1.
        tick(); tick();
        RegWrite = 1'b0;
        #2 reset = 1'b0;
        ra1 = 5'd3; #1;
        checks++;
        if (rd1 !== 32'h0 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_no_write rd1=%h cnt=%h exp 0/0", rd1, wr_count);
        end
        tick();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i);
            #1;
            checks++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                errors++;
                $display("FAIL post_reset_read addr=%0d rd1=%h rd2=%h exp 0", i, rd1, rd2);
            end
        end
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; stall = 1'b0; wa = 5'd8; wd = 32'hDEADBEEF; ra1 = 5'd8; ra2 = 5'd8;
        #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle rd1=%h rd2=%h exp DEADBEEF", rd1, rd2);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF || wr_count !== 16'd1) begin
            errors++;
            $display("FAIL bypass_stored rd1=%h cnt=%h exp DEADBEEF/1", rd1, wr_count);
        end
    endtask

    task automatic test_zero_write();
        logic [15:0] cnt_before;
        cnt_before = wr_count;
        RegWrite = 1'b1; stall = 1'b0; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_bypass rd1=%h rd2=%h exp 0", rd1, rd2);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'h0 || wr_count !== cnt_before) begin
            errors++;
            $display("FAIL zero_write rd1=%h cnt=%h exp 0/%h", rd1, wr_count, cnt_before);
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] old_val;
        old_val = model_regs[RA_INDEX];
        RegWrite = 1'b1; stall = 1'b1; wa = 5'(RA_INDEX); wd = 32'h00400010;
        ra2 = 5'(RA_INDEX); ra1 = 5'd8;
        #1;
        checks++;
        if (rd2 !== old_val) begin
            errors++;
            $display("FAIL stall_no_bypass rd2=%h exp %h", rd2, old_val);
        end
        tick();
        checks++;
        if (rd2 !== old_val || wr_count !== 16'(model_count)) begin
            errors++;
            $display("FAIL stall_frozen rd2=%h cnt=%h exp %h/%h", rd2, wr_count, old_val, 16'(model_count));
        end
        stall = 1'b0;
        #1;
        checks++;
        if (rd2 !== 32'h00400010) begin
            errors++;
            $display("FAIL unstall_bypass rd2=%h exp 00400010", rd2);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd2 !== 32'h00400010 || wr_count !== 16'd2) begin
            errors++;
            $display("FAIL unstall_commit rd2=%h cnt=%h exp 00400010/2", rd2, wr_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            RegWrite = 1'($urandom_range(0, 3) != 0);
            stall    = 1'($urandom_range(0, 4) == 0);
            wa       = 5'($urandom);
            wd       = $urandom;
            ra1      = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            ra2      = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
`ifdef REGFILE_DEBUG_PORT_EN
            dbg_addr = 5'($urandom);
`endif
            #1;
            checks++;
            if (rd1 !== expect_rd(ra1) || rd2 !== expect_rd(ra2)) begin
                errors++;
                $display("FAIL random_read n=%0d ra1=%0d rd1=%h exp %h ra2=%0d rd2=%h exp %h",
                         n, ra1, rd1, expect_rd(ra1), ra2, rd2, expect_rd(ra2));
            end
`ifdef REGFILE_DEBUG_PORT_EN
            checks++;
            if (dbg_data !== ((dbg_addr == 0) ? 32'h0 : model_regs[dbg_addr])) begin
                errors++;
                $display("FAIL random_dbg addr=%0d got %h exp %h", dbg_addr, dbg_data, model_regs[dbg_addr]);
            end
`endif
            tick();
            checks++;
            if (wr_count !== 16'(model_count)) begin
                errors++;
                $display("FAIL random_count n=%0d got %h exp %h", n, wr_count, 16'(model_count));
            end
        end
        RegWrite = 1'b0; stall = 1'b0;
    endtask

    task automatic test_async_reset();
        RegWrite = 1'b1; stall = 1'b0; wa = 5'd5; wd = 32'hA5A5A5A5; ra1 = 5'd5;
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL async_pre rd1=%h exp A5A5A5A5", rd1);
        end
        // Raise reset mid-cycle, well away from either clock edge.
        #1 reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if (rd1 !== 32'h0 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset rd1=%h cnt=%h exp 0/0", rd1, wr_count);
        end
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin
            errors++;
            $display("FAIL async_release rd1=%h exp 0", rd1);
        end
    endtask

    task automatic test_saturation();
        logic [DATA_W-1:0] last_wd;
        RegWrite = 1'b1; stall = 1'b0; wa = 5'd1; ra1 = 5'd1; ra2 = 5'd0;
        last_wd = '0;
        for (int n = 0; n < 65534; n++) begin
            wd = $urandom; last_wd = wd;
            tick();
        end
        checks++;
        if (wr_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_before got %h exp FFFE", wr_count);
        end
        for (int n = 0; n < 2; n++) begin
            wd = $urandom; last_wd = wd;
            tick();
            checks++;
            if (wr_count !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_hold step=%0d got %h exp FFFF", n, wr_count);
            end
        end
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd1 !== last_wd || rd1 !== model_regs[1]) begin
            errors++;
            $display("FAIL sat_last_data got %h exp %h", rd1, last_wd);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_write();
        test_stall();
        test_random();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
